// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared constants, FSM state type and abs-diff helper for match_detect
package match_pkg;

    localparam int CH_W        = 8;
    localparam int SUM_W       = 10;
    localparam int RUN_LEN_DEF = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        HIT_PEND = 2'd2
    } state_e;

    function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/match_absdiff3.sv
// rtl/match_absdiff3.sv - combinational per-channel |a-b| for three 8-bit channels
module match_absdiff3
    import match_pkg::*;
(
    input  logic [3*CH_W-1:0] a_i,
    input  logic [3*CH_W-1:0] b_i,
    output logic [3*CH_W-1:0] d_o
);

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        assign d_o[ch*CH_W +: CH_W] = abs_diff(a_i[ch*CH_W +: CH_W], b_i[ch*CH_W +: CH_W]);
    end

endmodule

// File: rtl/match_detect.sv
// rtl/match_detect.sv - run-of-matches detector on live vs delayed samples; MATCH_HIT_COUNT_EN enables hit_count
module match_detect
    import match_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int POS_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cur_data,
    input  logic [WIDTH-1:0] dly_data,
    input  logic [9:0]       tol,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [POS_W-1:0] hit_pos,
    output logic [15:0]      hit_count
);

    localparam logic [7:0] RUN_LEN_C = 8'(RUN_LEN);

    state_e             state_q;
    logic [7:0]         run_q;
    logic [7:0]         run_d;
    logic [POS_W-1:0]   start_q;
    logic [POS_W-1:0]   hit_pos_q;
    logic               hit_valid_q;

    logic [POS_W-1:0]   idx_q;
    logic [POS_W-1:0]   idx_d;
    logic               s1_valid_q;
    logic [3*CH_W-1:0]  s1_diff_q;
    logic [POS_W-1:0]   s1_idx_q;
    logic               s2_valid_q;
    logic [SUM_W-1:0]   s2_sum_q;
    logic [POS_W-1:0]   s2_idx_q;

    logic [3*CH_W-1:0]  diff;
    logic [SUM_W-1:0]   sum_d;
    logic               s2_match;
    logic               hit_hs;

    assign in_ready = (state_q != HIT_PEND) || hit_ready;
    assign hit_hs   = (state_q == HIT_PEND) && hit_ready;

    match_absdiff3 u_absdiff (
        .a_i (cur_data),
        .b_i (dly_data),
        .d_o (diff)
    );

    assign sum_d = {2'b00, s1_diff_q[0*CH_W +: CH_W]}
                 + {2'b00, s1_diff_q[1*CH_W +: CH_W]}
                 + {2'b00, s1_diff_q[2*CH_W +: CH_W]};

    // Compare against live tol so a tol change applies to the next decision consumed.
    assign s2_match = (s2_sum_q <= tol);
    assign idx_d    = idx_q + {{(POS_W-1){1'b0}}, 1'b1};
    assign run_d    = run_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_idx_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            s1_diff_q  <= diff;
            s1_idx_q   <= idx_q;
            s2_valid_q <= s1_valid_q;
            s2_sum_q   <= sum_d;
            s2_idx_q   <= s1_idx_q;
            if (in_valid) begin
                idx_q <= idx_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            run_q       <= '0;
            start_q     <= '0;
            hit_pos_q   <= '0;
            hit_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s2_valid_q) begin
                        if (s2_match) begin
                            state_q <= RUN;
                            run_q   <= 8'd1;
                            start_q <= s2_idx_q;
                        end else begin
                            run_q   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (s2_valid_q) begin
                        if (s2_match) begin
                            run_q <= run_d;
                            if (run_d == RUN_LEN_C) begin
                                state_q     <= HIT_PEND;
                                hit_pos_q   <= start_q;
                                hit_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                            run_q   <= '0;
                        end
                    end
                end
                HIT_PEND: begin
                    // Any decision leaving stage 2 in the handshake cycle is dropped.
                    if (hit_ready) begin
                        state_q     <= IDLE;
                        run_q       <= '0;
                        hit_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    run_q       <= '0;
                    hit_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_pos   = hit_pos_q;

`ifdef MATCH_HIT_COUNT_EN
    logic [15:0] hit_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else if (hit_hs && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_q <= hit_cnt_q + 16'd1;
        end
    end

    assign hit_count = hit_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = hit_hs;
    assign hit_count = 16'd0;
`endif

endmodule

// File: tb/tb_match_detect.sv
// tb/tb_match_detect.sv - scoreboard testbench for match_detect
module tb_match_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] cur_data = '0;
    logic [23:0] dly_data = '0;
    logic [9:0]  tol = '0;
    logic        hit_valid;
    logic        hit_ready = 1'b1;
    logic [15:0] hit_pos;
    logic [15:0] hit_count;

    match_detect #(.WIDTH(24), .RUN_LEN(20), .POS_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cur_data  (cur_data),
        .dly_data  (dly_data),
        .tol       (tol),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_pos   (hit_pos),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pos;
        int          at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   idx_m = 0;
    int   last_acc = 0;
    int   exp_cnt = 0;
    int   hits_seen = 0;
    logic prev_hv = 1'b0;

    // Per-channel diffs of 6 with mixed signs: total 18.
    localparam logic [23:0] D_CUR = {8'd200, 8'd50, 8'd100};
    localparam logic [23:0] D_DLY = {8'd206, 8'd44, 8'd106};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [23:0] c, input logic [23:0] d);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        cur_data = c;
        dly_data = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end else begin
            last_acc = cyc;
            idx_m++;
        end
    endtask

    task automatic send_matches(input int n);
        logic [23:0] x;
        for (int i = 0; i < n; i++) begin
            x = 24'($urandom);
            send(x, x);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_hit(input int pos);
        exp_t e;
        e.pos = 16'(pos);
        e.at  = last_acc + 2;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_hit_valid"}, 32'(hit_valid), 32'd0);
        check({tag, "_hit_pos"}, 32'(hit_pos), 32'd0);
        check({tag, "_hit_count"}, 32'(hit_count), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hv = 1'b0;
            exp_cnt = 0;
        end else begin
            check("hit_count", 32'(hit_count), 32'(exp_cnt));
            if (hit_valid && !prev_hv) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit: got hit pos %0d at cycle %0d expected none", hit_pos, cyc);
                end else begin
                    e = q.pop_front();
                    check("hit_pos", 32'(hit_pos), 32'(e.pos));
                    check("hit_latency", 32'(cyc), 32'(e.at));
                    hits_seen++;
                end
            end
`ifdef MATCH_HIT_COUNT_EN
            if (hit_valid && hit_ready && exp_cnt < 65535) exp_cnt++;
`endif
            prev_hv = hit_valid;
        end
    end

    initial begin
        int   base;
        logic ok;
        logic [23:0] x;

        hit_ready = 1'b0;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        hit_ready = 1'b1;
        idle(2);

        // Identical samples, tol 0: hit at index 0.
        tol = 10'd0;
        base = idx_m;
        send_matches(20);
        expect_hit(base);
        idle(8);

        // Sum of 18 fails at tol 17, passes at tol 18.
        tol = 10'd17;
        for (int i = 0; i < 25; i++) send(D_CUR, D_DLY);
        idle(8);
        tol = 10'd18;
        base = idx_m;
        for (int i = 0; i < 20; i++) send(D_CUR, D_DLY);
        expect_hit(base);
        idle(8);

        // 19 matches, a mismatch, then 20 matches.
        tol = 10'd0;
        base = idx_m;
        send_matches(19);
        x = 24'($urandom);
        send(x, x ^ 24'h000001);
        send_matches(20);
        expect_hit(base + 20);
        idle(8);

        // Consumer stalls 10 cycles; decision in the handshake cycle is dropped.
        hit_ready = 1'b0;
        base = idx_m;
        fork
            begin
                send_matches(20);
                expect_hit(base);
                send_matches(21);
                expect_hit(base + 21);
            end
            begin
                ok = 1'b0;
                for (int t = 0; t < 300 && !ok; t++) begin
                    @(negedge clk);
                    ok = hit_valid;
                end
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_wait: hit_valid stayed 0 expected 1");
                end
                repeat (10) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_hit_pos", 32'(hit_pos), 32'(base));
                end
                @(posedge clk);
                #1;
                hit_ready = 1'b1;
            end
        join
        idle(8);

        // Reset mid-run discards it; next run restarts at index 0.
        send_matches(15);
        in_valid = 1'b0;
        rst = 1'b1;
        idx_m = 0;
        hit_ready = 1'b0;
        check_reset_outputs("mid");
        check_reset_outputs("mid2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        hit_ready = 1'b1;
        idle(4);
        send_matches(20);
        expect_hit(0);
        idle(8);

        check("pending_hits", 32'(q.size()), 32'd0);
        check("hits_total", 32'(hits_seen), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
